// File: rtl/forth_pkg.sv
// Shared definitions for the Forth core sequencing blocks: phase encoding,
// sequencer states and the phase-rotation legality helper.
package forth_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int INSTR_W_DEF = 16;

  // Phase indices produced by the clock divisor; 0 and 4..7 are never legal.
  localparam logic [2:0] PH_X = 3'd1;
  localparam logic [2:0] PH_Y = 3'd2;
  localparam logic [2:0] PH_Z = 3'd3;

  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALTED = 3'd5
  } seq_state_e;

  // Only legal successor of phase p; from the reset value 0 the rotation
  // must start at PH_X. Garbage indices have no legal successor (returns 0).
  function automatic logic [2:0] next_phase(input logic [2:0] p);
    case (p)
      3'd0:    return PH_X;
      PH_X:    return PH_Y;
      PH_Y:    return PH_Z;
      PH_Z:    return PH_X;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/phase_edge_detect.sv
// Detects entry into a new divisor phase and flags out-of-order rotations.
module phase_edge_detect
  import forth_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] state_i,
  output logic       entry_o,
  output logic [2:0] entry_phase_o,
  output logic       illegal_o
);

  logic [2:0] prev_q;
  logic       legal;

  // Track the phase index seen on the previous cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= '0;
    else         prev_q <= state_i;
  end

  // An entry is any change of index; it is legal only along the rotation
  always_comb begin
    entry_o       = (state_i != prev_q);
    entry_phase_o = state_i;
    legal         = (state_i != 3'd0) && (state_i == next_phase(prev_q));
    illegal_o     = entry_o && !legal;
  end

endmodule

// File: rtl/phase_sequencer.sv
// Turns the divisor phase rotation into fetch/decode/execute enables for the
// Forth core; owns PC, IR and the retired-instruction counter.
module phase_sequencer
  import forth_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32
) (
  input  logic               i_CLOCK,
  input  logic               i_RESET_N,
  input  logic [2:0]         i_STATE,
  input  logic               i_MEM_READY,
  input  logic [INSTR_W-1:0] i_MEM_DATA,
  input  logic               i_BRANCH,
  input  logic [ADDR_W-1:0]  i_BRANCH_ADDR,
  input  logic               i_HALT,
  output logic               o_MEM_REQ,
  output logic [ADDR_W-1:0]  o_PC,
  output logic [INSTR_W-1:0] o_IR,
  output logic               o_DECODE_EN,
  output logic               o_EXEC_EN,
  output logic               o_STALL,
  output logic               o_HALTED,
  output logic               o_PHASE_ERR,
  output logic [CNT_W-1:0]   o_RETIRED
);

  logic       entry, illegal;
  logic [2:0] entry_phase;
  logic       enter_x, enter_y, enter_z;
  logic       mem_got;

  seq_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               irv_q, irv_d;   // IR holds the word for the current fetch
  logic               req_q, req_d;
  logic               dec_q, dec_d;
  logic               exe_q, exe_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   ret_q, ret_d;

  phase_edge_detect u_edge (
    .clk_i         (i_CLOCK),
    .rst_ni        (i_RESET_N),
    .state_i       (i_STATE),
    .entry_o       (entry),
    .entry_phase_o (entry_phase),
    .illegal_o     (illegal)
  );

  assign enter_x = entry && !illegal && (entry_phase == PH_X);
  assign enter_y = entry && !illegal && (entry_phase == PH_Y);
  assign enter_z = entry && !illegal && (entry_phase == PH_Z);
  // Ready arriving together with the phase-2 entry counts as already seen
  assign mem_got = irv_q || i_MEM_READY;

  // State, address, instruction and counter registers
  always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q <= ST_SYNC;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      irv_q   <= 1'b0;
      req_q   <= 1'b0;
      dec_q   <= 1'b0;
      exe_q   <= 1'b0;
      err_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      irv_q   <= irv_d;
      req_q   <= req_d;
      dec_q   <= dec_d;
      exe_q   <= exe_d;
      err_q   <= err_d;
      ret_q   <= ret_d;
    end
  end

  // Next-state logic; an illegal phase entry overrides all normal progress
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    irv_d   = irv_q;
    req_d   = req_q;
    dec_d   = 1'b0;
    exe_d   = 1'b0;
    err_d   = err_q || illegal;
    ret_d   = ret_q;
    if (illegal) begin
      state_d = ST_SYNC;
      req_d   = 1'b0;
      irv_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_SYNC: begin
          if (enter_x) begin
            state_d = ST_FETCH;
            req_d   = 1'b1;
            irv_d   = 1'b0;
          end
        end
        ST_FETCH, ST_WAIT: begin
          if (!irv_q && i_MEM_READY) begin
            ir_d  = i_MEM_DATA;
            irv_d = 1'b1;
            req_d = 1'b0;
          end
          if (enter_y) begin
            if (mem_got) begin
              state_d = ST_DECODE;
              dec_d   = 1'b1;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
        ST_DECODE: begin
          if (enter_z) begin
            state_d = ST_EXEC;
            exe_d   = 1'b1;
          end
        end
        ST_EXEC: begin
          pc_d  = i_BRANCH ? i_BRANCH_ADDR : pc_q + 1'b1;
          ret_d = ret_q + 1'b1;
          irv_d = 1'b0;
          if (i_HALT) begin
            state_d = ST_HALTED;
          end else if (enter_x) begin
            state_d = ST_FETCH;
            req_d   = 1'b1;
          end else begin
            state_d = ST_SYNC;
          end
        end
        ST_HALTED: begin
          if (enter_x && !i_HALT) begin
            state_d = ST_FETCH;
            req_d   = 1'b1;
          end
        end
        default: state_d = ST_SYNC;
      endcase
    end
  end

  assign o_MEM_REQ   = req_q;
  assign o_PC        = pc_q;
  assign o_IR        = ir_q;
  assign o_DECODE_EN = dec_q;
  assign o_EXEC_EN   = exe_q;
  assign o_STALL     = (state_q == ST_WAIT);
  assign o_HALTED    = (state_q == ST_HALTED);
  assign o_PHASE_ERR = err_q;
  assign o_RETIRED   = ret_q;

endmodule
